desired_drive_pipe: RTL and testbench
=====================================

Name: desired_drive_pipe

Overview:
Pipelined, parametrised successor to the combinational desired-drive calculation. Converts averaged torque, cadence, incline and assist scale into a motor target current. Adds a 3-stage multiply pipeline with a valid strobe and a per-update slew-rate limiter on the output. The limiter has an immediate drop to zero when the rider stops pedalling. Sits between the sensor/inertial conditioning logic and the PID/current-loop block.

Parameters:
TORQ_W, 12, avg_torque width
CAD_W, 5, cadence width
INC_W, 13, incline width (signed, INC_W >= 10)
SCALE_W, 3, assist scale width
CURR_W, 12, target_curr width
TORQUE_MIN, 12'h380, torque dead-band offset subtracted from avg_torque
PROD_SHIFT, 15, LSB of the product window mapped to target_curr
SLEW_STEP, 64, max |change| of target_curr per update; 0 = limiter bypassed

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
vld_in  in  1  new input sample strobe; inputs are sampled only when high
avg_torque  in  TORQ_W  averaged pedal torque, unsigned
cadence  in  CAD_W  cadence, unsigned
not_pedaling  in  1  rider not pedalling
incline  in  INC_W  signed incline
scale  in  SCALE_W  assist level
target_curr  out  CURR_W  slew-limited target current, unsigned
vld_out  out  1  one-cycle pulse when target_curr updates

Behaviour:
- Reset: rst_n low at a clk edge clears all pipeline data and valid bits, target_curr=0 and vld_out=0. Mid-stream reset discards in-flight samples; no vld_out is produced for them.
- Throughput: 1 sample/cycle; vld_in may be high every cycle. No back-pressure.
- Latency: vld_in high before edge E0 gives a vld_out pulse after edge E3 (4 edges, LATENCY=4). Samples exit in order.
- S1 (registered at E0), conditioning:
  - incline saturated to 10-bit signed [-512, 511], then +256, then clipped to incline_lim in [0, 511] (9 bits).
  - cadence_factor = (cadence > 1) ? cadence + 32 : 0, width CAD_W+1.
  - torque_pos = max(avg_torque - TORQUE_MIN, 0), computed in TORQ_W+1 bits.
  - scale and not_pedaling are registered alongside.
- S2 (E1): p_a = torque_pos * incline_lim; p_b = cadence_factor * scale. Widths are exact and nothing is truncated.
- S3 (E2):
  - prod = (not_pedaling) ? 0 : p_a * p_b, width P = TORQ_W + 9 + CAD_W + 1 + SCALE_W.
  - raw = all-ones if any prod bit >= PROD_SHIFT + CURR_W is set; otherwise raw = prod[PROD_SHIFT+CURR_W-1 : PROD_SHIFT].
  - The not_pedaling flag is carried forward to the limiter.
- Limiter (E3, only when the S3 valid bit is set):
  - If not_pedaling: target_curr = 0 immediately.
  - Else if SLEW_STEP = 0: target_curr = raw.
  - Else if raw > target + SLEW_STEP: target += SLEW_STEP.
  - Else if raw + SLEW_STEP < target: target -= SLEW_STEP.
  - Otherwise target = raw.
  - Comparisons are done in CURR_W+1 bits, so the result never wraps.
  - vld_out = 1 for that one cycle.
- target_curr holds its value between updates.

Decomposition:
- Package desired_drive_pkg holds:
  - INCLINE_OFFSET = 256, CADENCE_OFFSET = 32, CADENCE_MIN = 1, INC_LIM_W = 9, INC_SAT_W = 10, LATENCY = 4.
  - Default TORQUE_MIN.
  - Function sat_incline().
- One sub-module, drive_slew_limiter, implements the limiter stage. It is parametrised by CURR_W and SLEW_STEP, with inputs raw, raw_vld and np and outputs target and vld.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles while vld_in toggles -> target_curr=0 and vld_out=0 throughout; after reset release, first vld_out occurs exactly 4 cycles after the first vld_in.
2. Nominal, SLEW_STEP=0: avg_torque=12'h800, cadence=10, incline=0, scale=7, not_pedaling=0 -> product 86704128 -> target_curr=12'hA56 with vld_out 4 cycles after vld_in.
3. Saturation, SLEW_STEP=0: avg_torque=12'hFFF, incline=13'h0FFF (limits to 511), cadence=31, scale=7 -> product 720897849 >= 2^27 -> target_curr=12'hFFF.
4. Dead zones: any one of avg_torque=12'h37F, cadence=1, incline=-300 (13'h1ED4 -> factor -44 -> clipped 0), scale=0 or not_pedaling=1, with all other inputs as scenario 2 -> target_curr=0.
5. Slew, SLEW_STEP=64: repeat scenario-2 inputs -> target_curr 64, 128, … up to 2624, then 2646 on the next update. Then one not_pedaling sample -> target_curr=0 on the following vld_out.
6. Streaming: vld_in high 8 consecutive cycles with distinct inputs (SLEW_STEP=0) -> 8 consecutive vld_out pulses in order, values matching the reference model. Repeat, asserting rst_n=0 after the 3rd output -> remaining outputs are suppressed and target_curr=0.

Source files
------------

// File: rtl/desired_drive_pkg.sv
// Shared constants and helpers for the desired-drive pipeline.
// Incline conditioning functions live here so other blocks can reuse them.
package desired_drive_pkg;

    localparam int INCLINE_OFFSET = 256;
    localparam int CADENCE_OFFSET = 32;
    localparam int CADENCE_MIN    = 1;
    localparam int INC_LIM_W      = 9;
    localparam int INC_SAT_W      = 10;
    localparam int LATENCY        = 4;
    localparam int TORQUE_MIN_DEF = 'h380;

    // Saturate a sign-extended incline into INC_SAT_W signed bits.
    function automatic logic signed [INC_SAT_W-1:0] sat_incline(
        input int v
    );
        int hi;
        int lo;
        hi = (1 <<< (INC_SAT_W - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) begin
            return INC_SAT_W'(hi);
        end
        if (v < lo) begin
            return INC_SAT_W'(lo);
        end
        return INC_SAT_W'(v);
    endfunction

    // Shift the saturated incline up by the offset and clip to unsigned.
    function automatic logic [INC_LIM_W-1:0] clip_incline(
        input logic signed [INC_SAT_W-1:0] s
    );
        int v;
        v = int'(s) + INCLINE_OFFSET;
        if (v < 0) begin
            return '0;
        end
        if (v > (1 << INC_LIM_W) - 1) begin
            return '1;
        end
        return INC_LIM_W'(v);
    endfunction

endpackage

// File: rtl/desired_drive_pipe_if.sv
// Sample/result bundle between conditioning logic and the drive pipe.
// The source side drives the sample; the pipe drives the result.
interface desired_drive_pipe_if #(
    parameter int TORQ_W  = 12,
    parameter int CAD_W   = 5,
    parameter int INC_W   = 13,
    parameter int SCALE_W = 3,
    parameter int CURR_W  = 12
);

    logic               vld_in;
    logic [TORQ_W-1:0]  avg_torque;
    logic [CAD_W-1:0]   cadence;
    logic               not_pedaling;
    logic [INC_W-1:0]   incline;
    logic [SCALE_W-1:0] scale;
    logic [CURR_W-1:0]  target_curr;
    logic               vld_out;

    modport master (
        output vld_in,
        output avg_torque,
        output cadence,
        output not_pedaling,
        output incline,
        output scale,
        input  target_curr,
        input  vld_out
    );

    modport slave (
        input  vld_in,
        input  avg_torque,
        input  cadence,
        input  not_pedaling,
        input  incline,
        input  scale,
        output target_curr,
        output vld_out
    );

endinterface

// File: rtl/desired_drive_pipe_slew_limiter.sv
// Output stage: per-update slew limiting of the target current.
// Stopping pedalling forces the target straight to zero.
module drive_slew_limiter #(
    parameter int CURR_W    = 12,
    parameter int SLEW_STEP = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CURR_W-1:0] raw,
    input  logic              raw_vld,
    input  logic              np,
    output logic [CURR_W-1:0] target,
    output logic              vld
);

    localparam int XW = CURR_W + 1;

    logic [XW-1:0]     raw_x;
    logic [XW-1:0]     tgt_x;
    logic [XW-1:0]     step_x;
    logic [CURR_W-1:0] nxt;

    assign raw_x  = {1'b0, raw};
    assign tgt_x  = {1'b0, target};
    assign step_x = XW'(SLEW_STEP);

    // Next target: zero on stop, else move toward raw by at most one step.
    always_comb begin
        nxt = target;
        if (np) begin
            nxt = '0;
        end else if (SLEW_STEP == 0) begin
            nxt = raw;
        end else if (raw_x > tgt_x + step_x) begin
            nxt = CURR_W'(tgt_x + step_x);
        end else if (raw_x + step_x < tgt_x) begin
            nxt = CURR_W'(tgt_x - step_x);
        end else begin
            nxt = raw;
        end
    end

    // Update the target and pulse vld only when a new sample arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target <= '0;
            vld    <= 1'b0;
        end else begin
            vld <= raw_vld;
            if (raw_vld) begin
                target <= nxt;
            end
        end
    end

endmodule

// File: rtl/desired_drive_pipe.sv
// Pipelined desired-drive calculation: condition, multiply, slew limit.
// One sample per cycle, four-edge latency, no back-pressure.
module desired_drive_pipe
    import desired_drive_pkg::*;
#(
    parameter int TORQ_W     = 12,
    parameter int CAD_W      = 5,
    parameter int INC_W      = 13,
    parameter int SCALE_W    = 3,
    parameter int CURR_W     = 12,
    parameter int TORQUE_MIN = TORQUE_MIN_DEF,
    parameter int PROD_SHIFT = 15,
    parameter int SLEW_STEP  = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    desired_drive_pipe_if.slave bus
);

    localparam int CF_W = CAD_W + 1;
    localparam int PA_W = TORQ_W + INC_LIM_W;
    localparam int PB_W = CF_W + SCALE_W;
    localparam int PW   = PA_W + PB_W;
    localparam int TOP  = PROD_SHIFT + CURR_W;

    // Stage 1 combinational conditioning
    logic signed [INC_W-1:0]     inc_s;
    logic signed [INC_SAT_W-1:0] inc_sat;
    logic [INC_LIM_W-1:0]        inc_lim;
    logic [CF_W-1:0]             cad_f;
    logic [TORQ_W:0]             tdiff;
    logic [TORQ_W-1:0]           torq_pos;

    assign inc_s   = bus.incline;
    assign inc_sat = sat_incline(int'(inc_s));
    assign inc_lim = clip_incline(inc_sat);

    assign cad_f = (bus.cadence > CAD_W'(CADENCE_MIN))
                 ? {1'b0, bus.cadence} + CF_W'(CADENCE_OFFSET)
                 : '0;

    assign tdiff    = {1'b0, bus.avg_torque}
                    - {1'b0, TORQ_W'(TORQUE_MIN)};
    assign torq_pos = tdiff[TORQ_W] ? '0 : tdiff[TORQ_W-1:0];

    // Stage 1 registers
    logic                 v1;
    logic                 np1;
    logic [INC_LIM_W-1:0] inc1;
    logic [CF_W-1:0]      cad1;
    logic [TORQ_W-1:0]    torq1;
    logic [SCALE_W-1:0]   scale1;

    // Capture conditioned inputs on each accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            np1    <= 1'b0;
            inc1   <= '0;
            cad1   <= '0;
            torq1  <= '0;
            scale1 <= '0;
        end else begin
            v1 <= bus.vld_in;
            if (bus.vld_in) begin
                np1    <= bus.not_pedaling;
                inc1   <= inc_lim;
                cad1   <= cad_f;
                torq1  <= torq_pos;
                scale1 <= bus.scale;
            end
        end
    end

    // Stage 2 registers
    logic            v2;
    logic            np2;
    logic [PA_W-1:0] pa2;
    logic [PB_W-1:0] pb2;

    // Form the two partial products at full width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            np2 <= 1'b0;
            pa2 <= '0;
            pb2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                np2 <= np1;
                pa2 <= PA_W'(torq1) * PA_W'(inc1);
                pb2 <= PB_W'(cad1) * PB_W'(scale1);
            end
        end
    end

    // Stage 3 combinational: final product and output window
    logic [PW-1:0]     prod;
    logic              ovf;
    logic [CURR_W-1:0] raw;

    assign prod = np2 ? '0 : PW'(pa2) * PW'(pb2);
    assign ovf  = |(prod >> TOP);
    assign raw  = ovf ? '1 : CURR_W'(prod >> PROD_SHIFT);

    // Stage 3 registers
    logic              v3;
    logic              np3;
    logic [CURR_W-1:0] raw3;

    // Register the saturated window for the limiter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3   <= 1'b0;
            np3  <= 1'b0;
            raw3 <= '0;
        end else begin
            v3 <= v2;
            if (v2) begin
                np3  <= np2;
                raw3 <= raw;
            end
        end
    end

    drive_slew_limiter #(
        .CURR_W    (CURR_W),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     (raw3),
        .raw_vld (v3),
        .np      (np3),
        .target  (bus.target_curr),
        .vld     (bus.vld_out)
    );

endmodule

// File: tb/tb_desired_drive_pipe.sv
// Directed bench for desired_drive_pipe, with and without slew limiting.
// Two instances see identical stimulus; each check is an immediate assert.
module tb_desired_drive_pipe;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    desired_drive_pipe_if bus0 ();
    desired_drive_pipe_if bus1 ();

    desired_drive_pipe #(.SLEW_STEP(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    desired_drive_pipe #(.SLEW_STEP(64)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int tq, input int cd,
                         input int inc, input int sc, input logic np);
        bus0.vld_in       = v;
        bus0.avg_torque   = 12'(tq);
        bus0.cadence      = 5'(cd);
        bus0.incline      = 13'(inc);
        bus0.scale        = 3'(sc);
        bus0.not_pedaling = np;
        bus1.vld_in       = v;
        bus1.avg_torque   = 12'(tq);
        bus1.cadence      = 5'(cd);
        bus1.incline      = 13'(inc);
        bus1.scale        = 3'(sc);
        bus1.not_pedaling = np;
    endtask

    // One isolated sample; checks the four-edge latency on both instances.
    task automatic send(input string tag, input int tq, input int cd,
                        input int inc, input int sc, input logic np,
                        output int t0, output int t1);
        @(posedge clk); #1;
        drive(1'b1, tq, cd, inc, sc, np);
        @(posedge clk); #1;
        drive(1'b0, tq, cd, inc, sc, np);
        @(posedge clk);
        @(posedge clk); #1;
        chk({tag, "_vld_early"}, int'(bus0.vld_out), 0);
        @(posedge clk); #1;
        chk({tag, "_vld0"}, int'(bus0.vld_out), 1);
        chk({tag, "_vld1"}, int'(bus1.vld_out), 1);
        t0 = int'(bus0.target_curr);
        t1 = int'(bus1.target_curr);
    endtask

    function automatic int model(input int tq, input int cd, input int inc,
                                 input int sc, input int np);
        int     tp;
        int     s;
        int     cf;
        longint p;
        longint r;
        tp = tq - 'h380;
        if (tp < 0) tp = 0;
        s = inc;
        if (s > 511) s = 511;
        if (s < -512) s = -512;
        s = s + 256;
        if (s < 0) s = 0;
        if (s > 511) s = 511;
        cf = (cd > 1) ? cd + 32 : 0;
        p = longint'(tp) * s * cf * sc;
        if (np != 0) p = 0;
        r = p >>> 15;
        if (r > 4095) r = 4095;
        return int'(r);
    endfunction

    int st_tq [8] = '{'h800, 'h9A0, 'hFFF, 'h37F,
                      'hC00, 'hA00, 'h500, 'hE00};
    int st_cd [8] = '{10, 20, 31, 10, 2, 15, 31, 8};
    int st_inc[8] = '{0, 100, 511, 0, -100, 300, -600, 50};
    int st_sc [8] = '{7, 5, 7, 7, 3, 4, 6, 1};
    int st_np [8] = '{0, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        int t0;
        int t1;
        int e;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 1'b0);

        // Reset held while vld_in toggles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_tgt", int'(bus0.target_curr), 0);
            chk("rst_vld", int'(bus0.vld_out), 0);
            chk("rst_tgt1", int'(bus1.target_curr), 0);
            bus0.vld_in = ~bus0.vld_in;
            bus1.vld_in = bus0.vld_in;
        end
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;

        // Nominal
        send("nominal", 'h800, 10, 0, 7, 1'b0, t0, t1);
        chk("nominal_tgt", t0, 'hA56);

        // Saturation
        send("sat", 'hFFF, 31, 'h0FFF, 7, 1'b0, t0, t1);
        chk("sat_tgt", t0, 'hFFF);

        // Dead zones
        send("dz_torq", 'h37F, 10, 0, 7, 1'b0, t0, t1);
        chk("dz_torq_tgt", t0, 0);
        send("dz_cad", 'h800, 1, 0, 7, 1'b0, t0, t1);
        chk("dz_cad_tgt", t0, 0);
        send("dz_inc", 'h800, 10, 'h1ED4, 7, 1'b0, t0, t1);
        chk("dz_inc_tgt", t0, 0);
        send("dz_scale", 'h800, 10, 0, 0, 1'b0, t0, t1);
        chk("dz_scale_tgt", t0, 0);
        send("dz_np", 'h800, 10, 0, 7, 1'b1, t0, t1);
        chk("dz_np_tgt", t0, 0);

        // Slew ramp on the limited instance, starting from reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("slew_start", int'(bus1.target_curr), 0);
        for (int i = 0; i < 42; i++) begin
            send("slew", 'h800, 10, 0, 7, 1'b0, t0, t1);
            e = (i < 41) ? 64 * (i + 1) : 2646;
            chk($sformatf("slew_%0d", i), t1, e);
        end
        send("slew_np", 'h800, 10, 0, 7, 1'b1, t0, t1);
        chk("slew_np_tgt", t1, 0);

        // Streaming, eight back-to-back samples
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k >= 4) begin
                e = model(st_tq[k-4], st_cd[k-4], st_inc[k-4],
                          st_sc[k-4], st_np[k-4]);
                chk($sformatf("strm_vld_%0d", k - 4),
                    int'(bus0.vld_out), 1);
                chk($sformatf("strm_tgt_%0d", k - 4),
                    int'(bus0.target_curr), e);
            end else begin
                chk("strm_idle", int'(bus0.vld_out), 0);
            end
            if (k < 8) begin
                drive(1'b1, st_tq[k], st_cd[k], st_inc[k],
                      st_sc[k], st_np[k] != 0);
            end else begin
                drive(1'b0, 0, 0, 0, 0, 1'b0);
            end
        end

        // Streaming again, reset after the third output
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k >= 4 && k <= 6) begin
                e = model(st_tq[k-4], st_cd[k-4], st_inc[k-4],
                          st_sc[k-4], st_np[k-4]);
                chk($sformatf("rstrm_tgt_%0d", k - 4),
                    int'(bus0.target_curr), e);
                chk($sformatf("rstrm_vld_%0d", k - 4),
                    int'(bus0.vld_out), 1);
            end else if (k > 6) begin
                chk($sformatf("rstrm_sup_vld_%0d", k),
                    int'(bus0.vld_out), 0);
                chk($sformatf("rstrm_sup_tgt_%0d", k),
                    int'(bus0.target_curr), 0);
            end
            if (k == 6) begin
                rst_n = 1'b0;
            end
            if (k < 8) begin
                drive(1'b1, st_tq[k], st_cd[k], st_inc[k],
                      st_sc[k], st_np[k] != 0);
            end else begin
                drive(1'b0, 0, 0, 0, 0, 1'b0);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("post_rst_vld", int'(bus0.vld_out), 0);
            chk("post_rst_tgt", int'(bus0.target_curr), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
